// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write arbiter with burst locking and occupancy tracking for a shared FIFO
//
// Shares one FIFO write port between NUM_REQ requesters. Each accepted beat is
// written to the FIFO on the following cycle through registered strobes.
//
// Optional feature (macro FIFO_ARB_PRIO0_EN): requester 0 wins IDLE
// arbitration whenever it is valid. A grant won this way leaves the
// round-robin pointer unchanged, and it never preempts an active lock.
//
// Ports:
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   req_valid     per-requester beat valid
//   req_last      per-requester final beat of burst
//   req_data      packed payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready     per-requester accept, one-hot or zero
//   fifo_wr_en    registered write strobe
//   fifo_wr_data  registered write payload, holds when idle
//   fifo_rd_en    consumer pop pulse
//   fifo_full     occupancy == FIFO_CAP
//   fifo_empty    occupancy == 0
//   occupancy     current entry count
//   grant_id      last or current granted requester
//   busy          high while a burst lock is held
//   underflow_err sticky, pop seen while empty
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_CAP   = 15,
    parameter int MAX_BURST  = 8,
    localparam int IW = $clog2(NUM_REQ),
    localparam int OW = $clog2(FIFO_CAP + 1),
    localparam int CW = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    input  logic                          fifo_rd_en,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [OW-1:0]                 occupancy,
    output logic [IW-1:0]                 grant_id,
    output logic                          busy,
    output logic                          underflow_err
);
    typedef enum logic {IDLE, LOCK} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [IW-1:0]   lock_q, lock_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [OW-1:0]   occ_q, occ_d;
    logic            wr_en_q;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [IW-1:0]   gid_q, gid_d;
    logic            uf_q, uf_d;

    logic [IW-1:0]   sel, nxt;
    logic            hit, acc, adv, dec;
    int              idx;

    assign fifo_full     = occ_q == OW'(FIFO_CAP);
    assign fifo_empty    = occ_q == '0;
    assign occupancy     = occ_q;
    assign fifo_wr_en    = wr_en_q;
    assign fifo_wr_data  = wr_data_q;
    assign grant_id      = gid_q;
    assign busy          = state_q == LOCK;
    assign underflow_err = uf_q;

    // Candidate selection: the locked requester in LOCK, otherwise the first
    // valid requester scanning upward from the rr pointer with wrap.
    always_comb begin
        sel = '0;
        hit = 1'b0;
        idx = 0;
        if (state_q == LOCK) begin
            sel = lock_q;
            hit = req_valid[lock_q];
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_q) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!hit && req_valid[idx]) begin
                    hit = 1'b1;
                    sel = IW'(idx);
                end
            end
`ifdef FIFO_ARB_PRIO0_EN
            if (req_valid[0]) begin
                hit = 1'b1;
                sel = '0;
            end
`endif
        end
    end

    assign acc       = hit && !fifo_full;
    assign req_ready = acc ? (NUM_REQ'(1) << sel) : '0;
    assign nxt       = (sel == IW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
`ifdef FIFO_ARB_PRIO0_EN
    assign adv = sel != '0;
`else
    assign adv = 1'b1;
`endif
    assign dec       = fifo_rd_en && occ_q != '0;
    assign occ_d     = occ_q + OW'(acc) - OW'(dec);
    assign uf_d      = uf_q | (fifo_rd_en && occ_q == '0);
    assign wr_data_d = acc ? req_data[sel*DATA_WIDTH +: DATA_WIDTH] : wr_data_q;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        lock_d  = lock_q;
        cnt_d   = cnt_q;
        gid_d   = acc ? sel : gid_q;
        if (acc && state_q == IDLE) begin
            if (!req_last[sel] && MAX_BURST > 1) begin
                state_d = LOCK;
                lock_d  = sel;
                cnt_d   = CW'(1);
            end else if (adv) begin
                rr_d = nxt;
            end
        end else if (acc) begin
            // Release on the final beat or once the burst budget is spent.
            if (req_last[sel] || cnt_q >= CW'(MAX_BURST - 1)) begin
                state_d = IDLE;
                cnt_d   = '0;
                if (adv) rr_d = nxt;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            lock_q    <= '0;
            cnt_q     <= '0;
            occ_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            gid_q     <= '0;
            uf_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            lock_q    <= lock_d;
            cnt_q     <= cnt_d;
            occ_q     <= occ_d;
            wr_en_q   <= acc;
            wr_data_q <= wr_data_d;
            gid_q     <= gid_d;
            uf_q      <= uf_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    logic         clk = 1'b0;
    logic         reset_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_last;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         fifo_wr_en;
    logic [31:0]  fifo_wr_data;
    logic         fifo_rd_en;
    logic         fifo_full;
    logic         fifo_empty;
    logic [3:0]   occupancy;
    logic [1:0]   grant_id;
    logic         busy;
    logic         underflow_err;

    int errs = 0;
    int checks = 0;

    fifo_wr_arbiter dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(req_ready), .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data), .fifo_rd_en(fifo_rd_en), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .occupancy(occupancy), .grant_id(grant_id),
        .busy(busy), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic rd);
        @(negedge clk);
        req_valid  = v;
        req_last   = l;
        fifo_rd_en = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n    = 1'b1;
        req_valid  = '0;
        req_last   = '0;
        fifo_rd_en = 1'b0;
        for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'hA0 + i;
        #1 reset_n = 1'b0;
        #2;
        checks++;
        if ({fifo_wr_en, fifo_empty, fifo_full, busy, underflow_err, req_ready} !== 9'b010000000) begin
            errs++;
            $display("FAIL reset_flags got=%b exp=010000000",
                     {fifo_wr_en, fifo_empty, fifo_full, busy, underflow_err, req_ready});
        end
        checks++;
        if ({occupancy, grant_id, fifo_wr_data} !== 38'd0) begin
            errs++;
            $display("FAIL reset_values occ=%0d gid=%0d data=%h exp=0", occupancy, grant_id, fifo_wr_data);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_underflow();
        for (int p = 0; p < 3; p++) begin
            drive(4'b0000, 4'b0000, 1'b1);
            tick();
            checks++;
            if ({underflow_err, fifo_empty, occupancy, req_ready} !== {1'b1, 1'b1, 4'd0, 4'd0}) begin
                errs++;
                $display("FAIL underflow pop%0d uf=%b empty=%b occ=%0d ready=%b exp uf=1 empty=1 occ=0 ready=0000",
                         p, underflow_err, fifo_empty, occupancy, req_ready);
            end
        end
    endtask

    task automatic test_rr_fill();
        for (int k = 0; k < 15; k++) begin
            drive(4'b1111, 4'b1111, 1'b0);
            checks++;
            if (req_ready !== 4'(1 << (k % 4))) begin
                errs++;
                $display("FAIL rr_ready beat%0d got=%b exp=%b", k, req_ready, 4'(1 << (k % 4)));
            end
            tick();
            checks++;
            if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 32'hA0 + 32'(k % 4) || occupancy !== 4'(k + 1)
                || grant_id !== 2'(k % 4)) begin
                errs++;
                $display("FAIL rr_write beat%0d en=%b data=%h occ=%0d gid=%0d exp en=1 data=%h occ=%0d gid=%0d",
                         k, fifo_wr_en, fifo_wr_data, occupancy, grant_id, 32'hA0 + 32'(k % 4), k + 1, k % 4);
            end
        end
        drive(4'b1111, 4'b1111, 1'b0);
        checks++;
        if (req_ready !== 4'b0000 || fifo_full !== 1'b1) begin
            errs++;
            $display("FAIL full_block ready=%b full=%b exp ready=0000 full=1", req_ready, fifo_full);
        end
        tick();
        checks++;
        if (fifo_wr_en !== 1'b0 || fifo_wr_data !== 32'hA2 || occupancy !== 4'd15) begin
            errs++;
            $display("FAIL full_hold en=%b data=%h occ=%0d exp en=0 data=a2 occ=15", fifo_wr_en, fifo_wr_data, occupancy);
        end
    endtask

    task automatic test_full_pop();
        drive(4'b1111, 4'b1111, 1'b1);
        checks++;
        if (req_ready !== 4'b0000) begin
            errs++;
            $display("FAIL full_pop_ready got=%b exp=0000", req_ready);
        end
        tick();
        checks++;
        if (occupancy !== 4'd14 || fifo_wr_en !== 1'b0 || fifo_full !== 1'b0) begin
            errs++;
            $display("FAIL full_pop occ=%0d en=%b full=%b exp occ=14 en=0 full=0", occupancy, fifo_wr_en, fifo_full);
        end
        drive(4'b1111, 4'b1111, 1'b0);
        checks++;
        if (req_ready !== 4'b1000) begin
            errs++;
            $display("FAIL refill_ready got=%b exp=1000", req_ready);
        end
        tick();
        checks++;
        if (occupancy !== 4'd15 || fifo_wr_data !== 32'hA3 || fifo_wr_en !== 1'b1) begin
            errs++;
            $display("FAIL refill occ=%0d data=%h en=%b exp occ=15 data=a3 en=1", occupancy, fifo_wr_data, fifo_wr_en);
        end
        for (int p = 0; p < 15; p++) begin
            drive(4'b0000, 4'b0000, 1'b1);
            tick();
        end
        checks++;
        if (occupancy !== 4'd0 || fifo_empty !== 1'b1) begin
            errs++;
            $display("FAIL drain occ=%0d empty=%b exp occ=0 empty=1", occupancy, fifo_empty);
        end
    endtask

    task automatic test_burst_lock();
        drive(4'b0010, 4'b1111, 1'b0);
        tick();
        for (int b = 0; b < 3; b++) begin
            if (b == 2) begin
                drive(4'b0010, 4'b0000, 1'b0);
                checks++;
                if (req_ready !== 4'b0000) begin
                    errs++;
                    $display("FAIL lock_gap_ready got=%b exp=0000", req_ready);
                end
                tick();
                checks++;
                if (busy !== 1'b1 || fifo_wr_en !== 1'b0) begin
                    errs++;
                    $display("FAIL lock_gap busy=%b en=%b exp busy=1 en=0", busy, fifo_wr_en);
                end
            end
            drive(4'b0110, (b == 2) ? 4'b0100 : 4'b0000, 1'b0);
            checks++;
            if (req_ready !== 4'b0100) begin
                errs++;
                $display("FAIL lock_ready beat%0d got=%b exp=0100", b, req_ready);
            end
            tick();
            checks++;
            if (busy !== (b < 2) || grant_id !== 2'd2 || fifo_wr_data !== 32'hA2) begin
                errs++;
                $display("FAIL lock_beat%0d busy=%b gid=%0d data=%h exp busy=%b gid=2 data=a2",
                         b, busy, grant_id, fifo_wr_data, b < 2);
            end
        end
        drive(4'b1010, 4'b1111, 1'b0);
        checks++;
        if (req_ready !== 4'b1000) begin
            errs++;
            $display("FAIL after_lock_ready got=%b exp=1000", req_ready);
        end
        tick();
        drive(4'b0010, 4'b1111, 1'b0);
        checks++;
        if (req_ready !== 4'b0010) begin
            errs++;
            $display("FAIL wrap_ready got=%b exp=0010", req_ready);
        end
        tick();
        checks++;
        if (occupancy !== 4'd6 || grant_id !== 2'd1) begin
            errs++;
            $display("FAIL burst_occ occ=%0d gid=%0d exp occ=6 gid=1", occupancy, grant_id);
        end
        for (int p = 0; p < 6; p++) begin
            drive(4'b0000, 4'b0000, 1'b1);
            tick();
        end
    endtask

    task automatic test_forced_release();
        for (int b = 1; b <= 8; b++) begin
            drive(4'b0001, 4'b0000, 1'b0);
            checks++;
            if (req_ready !== 4'b0001) begin
                errs++;
                $display("FAIL force_ready beat%0d got=%b exp=0001", b, req_ready);
            end
            tick();
            checks++;
            if (busy !== (b < 8) || occupancy !== 4'(b)) begin
                errs++;
                $display("FAIL force_beat%0d busy=%b occ=%0d exp busy=%b occ=%0d", b, busy, occupancy, b < 8, b);
            end
        end
        drive(4'b0011, 4'b0000, 1'b0);
        checks++;
        if (req_ready !== 4'b0010) begin
            errs++;
            $display("FAIL force_next_ready got=%b exp=0010", req_ready);
        end
        tick();
        checks++;
        if (busy !== 1'b1 || fifo_wr_en !== 1'b1 || grant_id !== 2'd1) begin
            errs++;
            $display("FAIL force_next busy=%b en=%b gid=%0d exp busy=1 en=1 gid=1", busy, fifo_wr_en, grant_id);
        end
    endtask

    task automatic test_reset_mid_burst();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({fifo_wr_en, busy, underflow_err, fifo_empty} !== 4'b0001 || occupancy !== 4'd0 || grant_id !== 2'd0) begin
            errs++;
            $display("FAIL mid_reset en=%b busy=%b uf=%b empty=%b occ=%0d gid=%0d exp en=0 busy=0 uf=0 empty=1 occ=0 gid=0",
                     fifo_wr_en, busy, underflow_err, fifo_empty, occupancy, grant_id);
        end
        req_valid = '0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

`ifdef FIFO_ARB_PRIO0_EN
    task automatic test_prio0();
        drive(4'b0010, 4'b1111, 1'b0);
        tick();
        drive(4'b0101, 4'b1111, 1'b0);
        checks++;
        if (req_ready !== 4'b0001) begin
            errs++;
            $display("FAIL prio0_ready got=%b exp=0001", req_ready);
        end
        tick();
        drive(4'b0100, 4'b1111, 1'b0);
        checks++;
        if (req_ready !== 4'b0100) begin
            errs++;
            $display("FAIL prio0_ptr_ready got=%b exp=0100", req_ready);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_underflow();
        test_rr_fill();
        test_full_pop();
        test_burst_lock();
        test_forced_release();
        test_reset_mid_burst();
`ifdef FIFO_ARB_PRIO0_EN
        test_prio0();
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
